// File: rtl/mac_addr_filter.sv
// mac_addr_filter: RX destination-MAC filter with keep/drop verdict and saturating statistics
// Ports: i_clk/i_rst (async, active-high); RX word stream i_rx_data/i_wordNum/i_data_valid/i_recvDn;
//   config i_local_mac, i_mcast_tbl/i_mcast_en, i_mode, i_bcast_en, i_mcast_all, i_cnt_clr;
//   verdict o_recv_keep/o_verdict_vld/o_hit_type/o_hit_idx; counters o_pass_cnt/o_drop_cnt/o_runt_cnt.
module mac_addr_filter #(
    parameter int DATA_W    = 16,
    parameter int WORD_BASE = 1,
    parameter int N_MCAST   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     i_rx_data,
    input  logic [9:0]            i_wordNum,
    input  logic                  i_data_valid,
    input  logic                  i_recvDn,
    input  logic [47:0]           i_local_mac,
    input  logic [48*N_MCAST-1:0] i_mcast_tbl,
    input  logic [N_MCAST-1:0]    i_mcast_en,
    input  logic [1:0]            i_mode,
    input  logic                  i_bcast_en,
    input  logic                  i_mcast_all,
    input  logic                  i_cnt_clr,
    output logic                  o_recv_keep,
    output logic                  o_verdict_vld,
    output logic [2:0]            o_hit_type,
    output logic [3:0]            o_hit_idx,
    output logic [CNT_W-1:0]      o_pass_cnt,
    output logic [CNT_W-1:0]      o_drop_cnt,
    output logic [CNT_W-1:0]      o_runt_cnt
);
    localparam int WPM = 48 / DATA_W;
    typedef enum logic [1:0] {IDLE, CAP, DEC, HOLD} state_t;
    state_t state, state_nx;
    logic [47:0] da;
    logic [WPM-1:0] mask;
    logic in_range, cap_en, runt_inc, tbl_hit, v_keep;
    logic [2:0] v_type;
    logic [3:0] tbl_idx, v_idx;
    assign in_range = (i_wordNum >= 10'(WORD_BASE)) && (i_wordNum < 10'(WORD_BASE + WPM));
    assign cap_en   = i_data_valid && !i_recvDn && in_range && (state == IDLE || state == CAP);
    assign runt_inc = i_recvDn && (state == IDLE || state == CAP) && |mask;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cap_en ? CAP : IDLE;
            CAP:     state_nx = &mask ? DEC : CAP;
            default: state_nx = HOLD;
        endcase
        if (i_recvDn) state_nx = IDLE;
    end
    // Iterating downward leaves the lowest matching index in tbl_idx.
    always_comb begin
        tbl_hit = 1'b0;
        tbl_idx = '0;
        for (int k = N_MCAST - 1; k >= 0; k--)
            if (i_mcast_en[k] && i_mcast_tbl[48*k +: 48] == da) begin
                tbl_hit = 1'b1;
                tbl_idx = 4'(k);
            end
        v_type = i_mode == 2'b01 ? 3'd5 :
                 i_mode == 2'b10 ? 3'd0 :
                 i_mode == 2'b11 ? (da == i_local_mac ? 3'd2 : 3'd0) :
                 (&da && i_bcast_en) ? 3'd1 :
                 da == i_local_mac ? 3'd2 :
                 tbl_hit ? 3'd3 :
                 (i_mcast_all && da[40]) ? 3'd4 : 3'd0;
        v_idx  = v_type == 3'd3 ? tbl_idx : 4'd0;
        v_keep = v_type != 3'd0;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            da            <= '0;
            mask          <= '0;
            o_recv_keep   <= 1'b1;
            o_verdict_vld <= 1'b0;
            o_hit_type    <= '0;
            o_hit_idx     <= '0;
        end else begin
            o_verdict_vld <= state == DEC;
            if (state == DEC) begin
                o_recv_keep <= v_keep;
                o_hit_type  <= v_type;
                o_hit_idx   <= v_idx;
            end else if (i_recvDn || state != HOLD) begin
                o_recv_keep <= 1'b1;
            end
            if (i_recvDn || state == DEC) begin
                mask <= '0;
            end else begin
                for (int w = 0; w < WPM; w++)
                    if (cap_en && i_wordNum == 10'(WORD_BASE + w)) begin
                        da[(WPM-1-w)*DATA_W +: DATA_W] <= i_rx_data;
                        mask[w] <= 1'b1;
                    end
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pass_cnt <= '0;
            o_drop_cnt <= '0;
            o_runt_cnt <= '0;
        end else begin
            o_pass_cnt <= i_cnt_clr ? '0 : (state == DEC && v_keep && !(&o_pass_cnt)) ? o_pass_cnt + CNT_W'(1) : o_pass_cnt;
            o_drop_cnt <= i_cnt_clr ? '0 : (state == DEC && !v_keep && !(&o_drop_cnt)) ? o_drop_cnt + CNT_W'(1) : o_drop_cnt;
            o_runt_cnt <= i_cnt_clr ? '0 : (runt_inc && !(&o_runt_cnt)) ? o_runt_cnt + CNT_W'(1) : o_runt_cnt;
        end
    end
endmodule

// File: tb/tb_mac_addr_filter.sv
// tb_mac_addr_filter: randomized and directed check of mac_addr_filter against a verdict/counter model
module tb_mac_addr_filter;
    logic clk = 1'b0;
    logic rst, valid, rdn, valid8, rdn8, bcast_en, mcast_all, clr;
    logic [15:0] data;
    logic [7:0] data8;
    logic [9:0] wnum, wnum8;
    logic [47:0] lmac;
    logic [191:0] tbl;
    logic [3:0] en;
    logic [1:0] mode;
    logic keep, vld, keep8, vld8;
    logic [2:0] ht, ht8;
    logic [3:0] hi, hi8, pc, dc, rc, pc8, dc8, rc8;
    int n_chk = 0, n_fail = 0;
    int m_pass = 0, m_drop = 0, m_runt = 0;
    always #5 clk = ~clk;
    mac_addr_filter #(.DATA_W(16), .WORD_BASE(1), .N_MCAST(4), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(data), .i_wordNum(wnum), .i_data_valid(valid),
        .i_recvDn(rdn), .i_local_mac(lmac), .i_mcast_tbl(tbl), .i_mcast_en(en), .i_mode(mode),
        .i_bcast_en(bcast_en), .i_mcast_all(mcast_all), .i_cnt_clr(clr),
        .o_recv_keep(keep), .o_verdict_vld(vld), .o_hit_type(ht), .o_hit_idx(hi),
        .o_pass_cnt(pc), .o_drop_cnt(dc), .o_runt_cnt(rc));
    mac_addr_filter #(.DATA_W(8), .WORD_BASE(1), .N_MCAST(4), .CNT_W(4)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(data8), .i_wordNum(wnum8), .i_data_valid(valid8),
        .i_recvDn(rdn8), .i_local_mac(lmac), .i_mcast_tbl(tbl), .i_mcast_en(en), .i_mode(mode),
        .i_bcast_en(bcast_en), .i_mcast_all(mcast_all), .i_cnt_clr(clr),
        .o_recv_keep(keep8), .o_verdict_vld(vld8), .o_hit_type(ht8), .o_hit_idx(hi8),
        .o_pass_cnt(pc8), .o_drop_cnt(dc8), .o_runt_cnt(rc8));
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int sat(input int v);
        return v > 15 ? 15 : v;
    endfunction
    // Verdict straight from the filtering rules: returns {hit_type, hit_idx}.
    function automatic logic [6:0] ref_v(input logic [47:0] d);
        logic [2:0] t = 3'd0;
        logic [3:0] ix = 4'd0;
        if (mode == 2'd1) t = 3'd5;
        else if (mode == 2'd3) t = d == lmac ? 3'd2 : 3'd0;
        else if (mode == 2'd0) begin
            if (d == 48'hFFFF_FFFF_FFFF && bcast_en) t = 3'd1;
            else if (d == lmac) t = 3'd2;
            else begin
                for (int k = 0; k < 4; k++)
                    if (t == 3'd0 && en[k] && tbl[48*k +: 48] == d) begin
                        t = 3'd3;
                        ix = 4'(k);
                    end
                if (t == 3'd0 && mcast_all && d[40]) t = 3'd4;
            end
        end
        return {t, ix};
    endfunction
    task automatic chk_cnt();
        check("pass_cnt", 48'(pc), 48'(m_pass));
        check("drop_cnt", 48'(dc), 48'(m_drop));
        check("runt_cnt", 48'(rc), 48'(m_runt));
    endtask
    task automatic frame16(input logic [47:0] d, input int nw, input logic c);
        logic [6:0] r;
        int n;
        clr = c;
        if ($urandom_range(1, 0) == 1) begin
            @(posedge clk); #1;
            valid = 1'b1; wnum = 10'd0; data = 16'($urandom);
        end
        for (int w = 0; w < nw; w++) begin
            @(posedge clk); #1;
            valid = 1'b1; wnum = 10'(w + 1); data = d[47-16*w -: 16];
        end
        @(posedge clk); #1;
        valid = 1'b0;
        if (nw < 3) begin
            rdn = 1'b1;
            @(posedge clk); #1;
            rdn = 1'b0;
            if (nw > 0) m_runt = sat(m_runt + 1);
            check("runt_keep", 48'(keep), 48'd1);
            check("runt_vld", 48'(vld), 48'd0);
        end else begin
            r = ref_v(d);
            n = 0;
            while (!vld && n < 8) begin
                @(posedge clk); #1;
                n++;
            end
            check("latency", 48'(n), 48'd2);
            check("keep", 48'(keep), 48'(r[6:4] != 3'd0));
            check("hit_type", 48'(ht), 48'(r[6:4]));
            check("hit_idx", 48'(hi), 48'(r[3:0]));
            if (r[6:4] != 3'd0) m_pass = sat(m_pass + 1);
            else m_drop = sat(m_drop + 1);
            @(posedge clk); #1;
            check("vld_pulse", 48'(vld), 48'd0);
            check("keep_hold", 48'(keep), 48'(r[6:4] != 3'd0));
            rdn = 1'b1;
            @(posedge clk); #1;
            rdn = 1'b0;
            check("keep_idle", 48'(keep), 48'd1);
            check("type_held", 48'(ht), 48'(r[6:4]));
        end
        if (c) begin
            m_pass = 0; m_drop = 0; m_runt = 0;
        end
        clr = 1'b0;
        chk_cnt();
    endtask
    task automatic frame8(input logic [47:0] d);
        logic [6:0] r;
        int n;
        for (int w = 0; w < 6; w++) begin
            @(posedge clk); #1;
            valid8 = 1'b1; wnum8 = 10'(w + 1); data8 = d[47-8*w -: 8];
        end
        @(posedge clk); #1;
        valid8 = 1'b0;
        r = ref_v(d);
        n = 0;
        while (!vld8 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", 48'(n), 48'd2);
        check("w8_keep", 48'(keep8), 48'(r[6:4] != 3'd0));
        check("w8_hit_type", 48'(ht8), 48'(r[6:4]));
        rdn8 = 1'b1;
        @(posedge clk); #1;
        rdn8 = 1'b0;
    endtask
    task automatic chk_reset(input string tag);
        check({tag, "_keep"}, 48'(keep), 48'd1);
        check({tag, "_vld"}, 48'(vld), 48'd0);
        check({tag, "_type"}, 48'(ht), 48'd0);
        check({tag, "_idx"}, 48'(hi), 48'd0);
        chk_cnt();
    endtask
    initial begin
        logic [47:0] d;
        rst = 1'b1; valid = 1'b0; rdn = 1'b0; valid8 = 1'b0; rdn8 = 1'b0; clr = 1'b0;
        data = '0; data8 = '0; wnum = '0; wnum8 = '0;
        lmac = 48'h02_00_00_00_00_01; tbl = '0; en = '0; mode = 2'd0; bcast_en = 1'b1; mcast_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        frame16(lmac, 3, 1'b0);
        frame16(48'hFFFF_FFFF_FFFF, 3, 1'b0);
        bcast_en = 1'b0;
        frame16(48'hFFFF_FFFF_FFFF, 3, 1'b0);
        tbl[96 +: 48] = 48'h01005e000181;
        tbl[144 +: 48] = 48'h01005e000181;
        en = 4'b1100;
        frame16(48'h01005e000181, 3, 1'b0);
        en = 4'b1000;
        frame16(48'h01005e000181, 3, 1'b0);
        mcast_all = 1'b1; en = 4'b0000;
        frame16(48'h01005e000181, 3, 1'b0);
        mcast_all = 1'b0;
        frame16(lmac, 2, 1'b0);
        frame16(lmac, 1, 1'b0);
        frame16(lmac, 3, 1'b0);
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            frame16(48'h0a0b0c0d0e0f, 3, 1'b0);
            frame8(48'h0a0b0c0d0e0f);
        end
        mode = 2'd3;
        frame16(lmac, 3, 1'b0);
        frame8(lmac);
        mode = 2'd2;
        repeat (17) frame16(48'h0a0b0c0d0e0f, 3, 1'b0);
        frame16(48'h0a0b0c0d0e0f, 3, 1'b1);
        mode = 2'd1;
        frame16(lmac, 3, 1'b0);
        frame16(lmac, 2, 1'b0);
        for (int w = 0; w < 2; w++) begin
            @(posedge clk); #1;
            valid = 1'b1; wnum = 10'(w + 1); data = lmac[47-16*w -: 16];
        end
        @(posedge clk); #1;
        valid = 1'b0; rst = 1'b1;
        #1;
        m_pass = 0; m_drop = 0; m_runt = 0;
        chk_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            mode = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
            bcast_en = 1'($urandom);
            mcast_all = 1'($urandom);
            en = 4'($urandom);
            for (int k = 0; k < 4; k++) tbl[48*k +: 48] = {16'($urandom), $urandom};
            if ($urandom_range(1, 0) == 1) tbl[144 +: 48] = tbl[48 +: 48];
            case ($urandom_range(4, 0))
                0: d = lmac;
                1: d = 48'hFFFF_FFFF_FFFF;
                2: d = tbl[48*$urandom_range(3, 0) +: 48];
                3: d = {16'($urandom), $urandom} | 48'h0100_0000_0000;
                default: d = {16'($urandom), $urandom};
            endcase
            frame16(d, ($urandom_range(5, 0) == 0) ? $urandom_range(2, 0) : 3, $urandom_range(9, 0) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
